dut_test_sequencer: RTL and testbench
=====================================

Name: dut_test_sequencer

Overview:
Host-side controller for the DUT test environment. Accepts one command word per transaction from the host link and drives the environment bus: SEL, ADR, RnW, DATA_IN and START_FLAG. It waits for RDY_FLAG under a timeout, measures calculation latency, and returns the captured DATA_OUT or HEAD_INFO as one response word. It sits between the host command/response FIFOs and the DUT environment, and is the only driver of that bus.

Parameters:
BITWIDTH_DATA, 16, DUT data width
BITWIDTH_ADR, 6, DUT address width
NUM_DUT, 3, number of DUTs; valid SEL range is 1..NUM_DUT
NUM_BITS_HEADER, 32, header width; must be >= BITWIDTH_DATA
TIMEOUT_CYCLES, 1024, maximum WAIT cycles before abort (>= 2)
Derived: SW = $clog2(NUM_DUT)+1; CW = 2+SW+BITWIDTH_ADR+BITWIDTH_DATA

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
CMD_IN  in  CW  command word {OP[1:0], SEL, ADR, DATA}, MSB first
CMD_VALID  in  1  command present
CMD_READY  out  1  command accepted when VALID&READY
RSP_DATA  out  NUM_BITS_HEADER  response payload, zero-extended
RSP_STATUS  out  2  00 ok, 01 timeout, 10 invalid SEL
RSP_CYCLES  out  16  START-to-RDY latency in cycles, saturating at 16'hFFFF
RSP_VALID  out  1  response present
RSP_READY  in  1  host takes response
SEL  out  SW  DUT select
ADR  out  BITWIDTH_ADR  DUT address
RnW  out  1  1 = read
DATA_OUT_DUT  out  BITWIDTH_DATA  drives the environment DATA_IN
START_FLAG  out  1  single-cycle start pulse
DATA_IN_DUT  in  BITWIDTH_DATA  environment DATA_OUT
HEAD_INFO  in  NUM_BITS_HEADER  environment header
RDY_FLAG  in  1  environment ready
BUSY  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0, CMD_READY=0 during reset and 1 in the first IDLE cycle after reset, state=IDLE. Reset asserted mid-operation aborts at once, with no response emitted.
- Opcodes:
  - 00 HEAD: read the header.
  - 01 CALC: RnW=0, start the calculation with DATA.
  - 10 READ: RnW=1 at ADR.
  - 11 WRITE: RnW=0, write DATA at ADR.
- FSM states: IDLE, SETUP, START, WAIT, CAPTURE, RESPOND.
- IDLE:
  - CMD_READY=1 only in this state; SEL=0 (parked).
  - On VALID&READY, latch all fields.
  - If SEL==0 or SEL>NUM_DUT, go to RESPOND with status 10, data 0 and cycles 0; the bus stays parked.
  - Otherwise go to SETUP.
- SETUP (1 cycle):
  - Drive SEL, ADR, RnW and DATA_OUT_DUT from the latched fields. These stay stable until RESPOND.
  - HEAD goes to CAPTURE; all other ops go to START.
- START (1 cycle): START_FLAG=1, cycle counter cleared. Next state is WAIT.
- WAIT:
  - Counter increments every cycle.
  - RDY_FLAG is sampled from the first WAIT cycle and is level-sensitive. RDY_FLAG=1 goes to CAPTURE, with RSP_CYCLES = counter+1 (saturating).
  - If the counter reaches TIMEOUT_CYCLES-1 with no RDY: go to RESPOND with status 01, data 0 and RSP_CYCLES = TIMEOUT_CYCLES (saturated).
  - If RDY and timeout occur in the same cycle, RDY wins.
- CAPTURE (1 cycle):
  - HEAD: register HEAD_INFO, cycles 0.
  - CALC/READ: register DATA_IN_DUT.
  - WRITE: register the latched DATA (echo).
  - Status 00. Next state is RESPOND.
- RESPOND:
  - SEL returns to 0; RSP_* registered and RSP_VALID=1, held stable until RSP_READY.
  - On VALID&READY, go to IDLE. CMD_READY rises the next cycle, never in the same cycle.
- Minimum latency from command accept to RSP_VALID:
  - HEAD: 3 cycles.
  - RDY in the first WAIT cycle: 5 cycles.
- START_FLAG is never high outside START. At most one transaction is in flight.

Test Plan:
1. Reset mid-WAIT: RST pulse with CALC outstanding -> all outputs 0 within the same cycle, no RSP_VALID. A following HEAD command completes normally.
2. HEAD with SEL=1, HEAD_INFO=32'h0C00_1010 -> RSP_DATA=32'h0C00_1010, status 00, cycles 0, RSP_VALID 3 cycles after accept.
3. WRITE SEL=3, ADR=5, DATA=16'hBEEF, then READ SEL=3, ADR=5 against a RAM model with 2-cycle RDY delay -> read returns 16'hBEEF, status 00, RSP_CYCLES=2. RnW=1 during the read. START_FLAG high exactly 1 cycle per op.
4. CALC SEL=2 against a model that never raises RDY, TIMEOUT_CYCLES=16 -> status 01, data 0, RSP_CYCLES=16, SEL back to 0 in RESPOND.
5. Invalid SEL=0 and SEL=4 -> status 10, no START_FLAG, SEL stays 0, response 1 cycle after accept.
6. Back-pressure: RSP_READY held low 10 cycles with CMD_VALID high -> RSP fields stable, CMD_READY stays 0, next command accepted exactly 1 cycle after the RSP handshake.

Source files
------------

// File: rtl/dut_test_sequencer.sv
// Host-side test sequencer: takes one command word from the host, drives the
// DUT environment bus, waits for RDY_FLAG under a timeout, and returns one
// response word carrying captured data, a status code and the START-to-RDY latency.
module dut_test_sequencer #(
    parameter  int BITWIDTH_DATA   = 16,
    parameter  int BITWIDTH_ADR    = 6,
    parameter  int NUM_DUT         = 3,
    parameter  int NUM_BITS_HEADER = 32,
    parameter  int TIMEOUT_CYCLES  = 1024,
    localparam int SW              = $clog2(NUM_DUT) + 1,
    localparam int CW              = 2 + SW + BITWIDTH_ADR + BITWIDTH_DATA
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [CW-1:0]              CMD_IN,
    input  logic                       CMD_VALID,
    output logic                       CMD_READY,
    output logic [NUM_BITS_HEADER-1:0] RSP_DATA,
    output logic [1:0]                 RSP_STATUS,
    output logic [15:0]                RSP_CYCLES,
    output logic                       RSP_VALID,
    input  logic                       RSP_READY,
    output logic [SW-1:0]              SEL,
    output logic [BITWIDTH_ADR-1:0]    ADR,
    output logic                       RnW,
    output logic [BITWIDTH_DATA-1:0]   DATA_OUT_DUT,
    output logic                       START_FLAG,
    input  logic [BITWIDTH_DATA-1:0]   DATA_IN_DUT,
    input  logic [NUM_BITS_HEADER-1:0] HEAD_INFO,
    input  logic                       RDY_FLAG,
    output logic                       BUSY
);

    localparam int CNTW = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0] OP_HEAD  = 2'b00;
    localparam logic [1:0] OP_CALC  = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b11;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_BADSEL  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_START, S_WAIT, S_CAPTURE, S_RESPOND
    } state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 op_q, op_d;
    logic [SW-1:0]              sel_q, sel_d;
    logic [BITWIDTH_ADR-1:0]    adr_q, adr_d;
    logic [BITWIDTH_DATA-1:0]   data_q, data_d;
    logic [CNTW-1:0]            cnt_q, cnt_d;
    logic [NUM_BITS_HEADER-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]                 rsp_status_q, rsp_status_d;
    logic [15:0]                rsp_cycles_q, rsp_cycles_d;
    logic                       cmd_ready_q, cmd_ready_d;

    logic [1:0]                 cmd_op;
    logic [SW-1:0]              cmd_sel;
    logic [BITWIDTH_ADR-1:0]    cmd_adr;
    logic [BITWIDTH_DATA-1:0]   cmd_data;
    logic                       bus_active;

    assign cmd_op   = CMD_IN[CW-1 -: 2];
    assign cmd_sel  = CMD_IN[CW-3 -: SW];
    assign cmd_adr  = CMD_IN[BITWIDTH_DATA +: BITWIDTH_ADR];
    assign cmd_data = CMD_IN[BITWIDTH_DATA-1:0];

    // Latency counts wider than the response field clamp at all-ones.
    function automatic logic [15:0] sat16(input logic [31:0] v);
        return (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
    endfunction

    function automatic logic [NUM_BITS_HEADER-1:0] zext(input logic [BITWIDTH_DATA-1:0] v);
        return NUM_BITS_HEADER'(v);
    endfunction

    // State and datapath registers; reset aborts any transaction immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            sel_q        <= '0;
            adr_q        <= '0;
            data_q       <= '0;
            cnt_q        <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
            rsp_cycles_q <= '0;
            cmd_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            sel_q        <= sel_d;
            adr_q        <= adr_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            rsp_cycles_q <= rsp_cycles_d;
            cmd_ready_q  <= cmd_ready_d;
        end
    end

    // Next-state logic: command latch, WAIT timeout, response capture.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        sel_d        = sel_q;
        adr_d        = adr_q;
        data_d       = data_q;
        cnt_d        = cnt_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        rsp_cycles_d = rsp_cycles_q;

        case (state_q)
            S_IDLE: begin
                if (CMD_VALID && cmd_ready_q) begin
                    op_d         = cmd_op;
                    sel_d        = cmd_sel;
                    adr_d        = cmd_adr;
                    data_d       = cmd_data;
                    cnt_d        = '0;
                    rsp_data_d   = '0;
                    rsp_cycles_d = '0;
                    if ((cmd_sel == '0) || (int'(cmd_sel) > NUM_DUT)) begin
                        rsp_status_d = ST_BADSEL;
                        state_d      = S_RESPOND;
                    end else begin
                        rsp_status_d = ST_OK;
                        state_d      = S_SETUP;
                    end
                end
            end
            S_SETUP: state_d = (op_q == OP_HEAD) ? S_CAPTURE : S_START;
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A ready seen on the last allowed cycle still counts as success.
                if (RDY_FLAG) begin
                    rsp_cycles_d = sat16(32'(cnt_q) + 32'd1);
                    state_d      = S_CAPTURE;
                end else if (cnt_q == CNTW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_status_d = ST_TIMEOUT;
                    rsp_data_d   = '0;
                    rsp_cycles_d = sat16(32'(TIMEOUT_CYCLES));
                    state_d      = S_RESPOND;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            S_CAPTURE: begin
                case (op_q)
                    OP_HEAD: begin
                        rsp_data_d   = HEAD_INFO;
                        rsp_cycles_d = '0;
                    end
                    OP_CALC, OP_READ: rsp_data_d = zext(DATA_IN_DUT);
                    default:          rsp_data_d = zext(data_q);
                endcase
                rsp_status_d = ST_OK;
                state_d      = S_RESPOND;
            end
            S_RESPOND: begin
                if (RSP_READY) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Registered ready: rises the cycle after the response handshake.
        cmd_ready_d = (state_d == S_IDLE);
    end

    // The bus is driven only between SETUP and CAPTURE; otherwise parked at 0.
    assign bus_active   = (state_q == S_SETUP) || (state_q == S_START) ||
                          (state_q == S_WAIT)  || (state_q == S_CAPTURE);
    assign SEL          = bus_active ? sel_q  : '0;
    assign ADR          = bus_active ? adr_q  : '0;
    assign DATA_OUT_DUT = bus_active ? data_q : '0;
    assign RnW          = bus_active && ((op_q == OP_READ) || (op_q == OP_HEAD));
    assign START_FLAG   = (state_q == S_START);
    assign BUSY         = (state_q != S_IDLE);
    assign CMD_READY    = cmd_ready_q;
    assign RSP_VALID    = (state_q == S_RESPOND);
    assign RSP_DATA     = rsp_data_q;
    assign RSP_STATUS   = rsp_status_q;
    assign RSP_CYCLES   = rsp_cycles_q;

endmodule

// File: tb/tb_dut_test_sequencer.sv
// Directed bench for dut_test_sequencer with a small environment model:
// a RAM with a 2-cycle ready, a never-ready mode, and an immediate-ready
// calculator that returns the bitwise inverse of its input.
module tb_dut_test_sequencer;

    localparam int DW = 16;
    localparam int AW = 6;
    localparam int ND = 3;
    localparam int HW = 32;
    localparam int TO = 16;
    localparam int SW = 3;
    localparam int CW = 2 + SW + AW + DW;

    logic          CLK = 1'b0;
    logic          RST;
    logic [CW-1:0] CMD_IN;
    logic          CMD_VALID;
    logic          CMD_READY;
    logic [HW-1:0] RSP_DATA;
    logic [1:0]    RSP_STATUS;
    logic [15:0]   RSP_CYCLES;
    logic          RSP_VALID;
    logic          RSP_READY;
    logic [SW-1:0] SEL;
    logic [AW-1:0] ADR;
    logic          RnW;
    logic [DW-1:0] DATA_OUT_DUT;
    logic          START_FLAG;
    logic [DW-1:0] DATA_IN_DUT;
    logic [HW-1:0] HEAD_INFO;
    logic          RDY_FLAG;
    logic          BUSY;

    always #5 CLK = ~CLK;

    dut_test_sequencer #(
        .BITWIDTH_DATA(DW), .BITWIDTH_ADR(AW), .NUM_DUT(ND),
        .NUM_BITS_HEADER(HW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK), .RST(RST), .CMD_IN(CMD_IN), .CMD_VALID(CMD_VALID),
        .CMD_READY(CMD_READY), .RSP_DATA(RSP_DATA), .RSP_STATUS(RSP_STATUS),
        .RSP_CYCLES(RSP_CYCLES), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .SEL(SEL), .ADR(ADR), .RnW(RnW), .DATA_OUT_DUT(DATA_OUT_DUT),
        .START_FLAG(START_FLAG), .DATA_IN_DUT(DATA_IN_DUT), .HEAD_INFO(HEAD_INFO),
        .RDY_FLAG(RDY_FLAG), .BUSY(BUSY)
    );

    // Environment model
    int          mode;
    logic [31:0] head;
    int          dly;
    logic [15:0] ram [64];
    logic        start_prev;
    int          start_total  = 0;
    int          sel_nz_total = 0;
    int          dbl_start    = 0;
    logic        rnw_at_start = 1'b0;
    logic [2:0]  sel_at_start = 3'd0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            dly        <= 0;
            start_prev <= 1'b0;
            for (int i = 0; i < 64; i++) ram[i] <= 16'h0;
        end else begin
            if (START_FLAG) dly <= 2;
            else if (dly > 0) dly <= dly - 1;
            if (mode == 1 && START_FLAG && !RnW && SEL != 0) ram[ADR] <= DATA_OUT_DUT;
            start_prev <= START_FLAG;
        end
    end

    always @(posedge CLK) begin
        if (START_FLAG) begin
            start_total  <= start_total + 1;
            rnw_at_start <= RnW;
            sel_at_start <= SEL;
        end
        if (START_FLAG && start_prev) dbl_start <= dbl_start + 1;
        if (SEL != 0) sel_nz_total <= sel_nz_total + 1;
    end

    assign RDY_FLAG    = (mode == 2) || (mode == 1 && dly == 1);
    assign DATA_IN_DUT = (mode == 2) ? ~DATA_OUT_DUT : ram[ADR];
    assign HEAD_INFO   = head;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [2:0] sel, input logic [5:0] adr,
                        input logic [15:0] data, output bit ok);
        CMD_IN    = {op, sel, adr, data};
        CMD_VALID = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (CMD_READY) ok = 1'b1;
            tick();
        end
        CMD_VALID = 1'b0;
        if (!ok) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: CMD_READY never seen high");
        end
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!RSP_VALID && lat < 100) begin
            tick();
            lat++;
        end
        if (!RSP_VALID) begin
            compared++;
            mismatched++;
            $display("FAIL rsp_timeout: RSP_VALID never seen high");
        end
    endtask

    task automatic handshake();
        RSP_READY = 1'b1;
        tick();
        RSP_READY = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  sel;
        logic [5:0]  adr;
        logic [15:0] data;
        int          mode;
        logic [31:0] head;
        logic [31:0] exp_data;
        logic [1:0]  exp_st;
        logic [15:0] exp_cyc;
        int          exp_lat;
        int          exp_starts;
        logic        exp_rnw;
        logic [2:0]  exp_sel;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        bit ok;
        int lat, s0, n0;
        mode = v.mode;
        head = v.head;
        s0   = start_total;
        n0   = sel_nz_total;
        send(v.op, v.sel, v.adr, v.data, ok);
        if (!ok) return;
        wait_rsp(lat);
        check($sformatf("%s_latency", tag), 64'(lat), 64'(v.exp_lat));
        check($sformatf("%s_data", tag), 64'(RSP_DATA), 64'(v.exp_data));
        check($sformatf("%s_status", tag), 64'(RSP_STATUS), 64'(v.exp_st));
        check($sformatf("%s_cycles", tag), 64'(RSP_CYCLES), 64'(v.exp_cyc));
        check($sformatf("%s_rsp_bus", tag), 64'({SEL, START_FLAG, CMD_READY, BUSY}), 64'({3'd0, 1'b0, 1'b0, 1'b1}));
        handshake();
        check($sformatf("%s_after_hs", tag), 64'({CMD_READY, RSP_VALID, BUSY}), 64'({1'b1, 1'b0, 1'b0}));
        check($sformatf("%s_starts", tag), 64'(start_total - s0), 64'(v.exp_starts));
        if (v.exp_starts > 0)
            check($sformatf("%s_bus_at_start", tag), 64'({rnw_at_start, sel_at_start}), 64'({v.exp_rnw, v.exp_sel}));
        else if (v.exp_st == 2'b10)
            check($sformatf("%s_sel_parked", tag), 64'(sel_nz_total - n0), 64'(0));
    endtask

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        int lat;
        vec_t hv;

        vecs[0] = '{2'b00, 3'd1, 6'd0, 16'h0000, 0, 32'h0C00_1010, 32'h0C00_1010, 2'b00, 16'd0,  3,  0, 1'b0, 3'd0};
        vecs[1] = '{2'b11, 3'd3, 6'd5, 16'hBEEF, 1, 32'h0,         32'h0000_BEEF, 2'b00, 16'd2,  6,  1, 1'b0, 3'd3};
        vecs[2] = '{2'b10, 3'd3, 6'd5, 16'h0000, 1, 32'h0,         32'h0000_BEEF, 2'b00, 16'd2,  6,  1, 1'b1, 3'd3};
        vecs[3] = '{2'b01, 3'd2, 6'd9, 16'h1234, 0, 32'h0,         32'h0,         2'b01, 16'd16, 19, 1, 1'b0, 3'd2};
        vecs[4] = '{2'b00, 3'd0, 6'd0, 16'h0000, 0, 32'h1111_2222, 32'h0,         2'b10, 16'd0,  1,  0, 1'b0, 3'd0};
        vecs[5] = '{2'b10, 3'd4, 6'd5, 16'h0000, 1, 32'h0,         32'h0,         2'b10, 16'd0,  1,  0, 1'b0, 3'd0};
        vecs[6] = '{2'b01, 3'd1, 6'd7, 16'h1234, 2, 32'h0,         32'h0000_EDCB, 2'b00, 16'd1,  5,  1, 1'b0, 3'd1};
        vecs[7] = '{2'b00, 3'd2, 6'd0, 16'h0000, 0, 32'hFFFF_0001, 32'hFFFF_0001, 2'b00, 16'd0,  3,  0, 1'b0, 3'd0};

        RST = 1'b1; CMD_VALID = 1'b0; CMD_IN = '0; RSP_READY = 1'b0; mode = 0; head = 32'h0;
        repeat (3) tick();
        check("reset_ctrl", 64'({CMD_READY, RSP_VALID, BUSY, START_FLAG, SEL, ADR, RnW, DATA_OUT_DUT}), 64'(0));
        check("reset_rsp", 64'({RSP_STATUS, RSP_CYCLES, RSP_DATA}), 64'(0));
        RST = 1'b0;
        tick();
        check("ready_after_reset", 64'({CMD_READY, BUSY}), 64'({1'b1, 1'b0}));

        // Reset while a CALC sits in WAIT
        mode = 0;
        send(2'b01, 3'd2, 6'd3, 16'h5555, ok);
        repeat (4) tick();
        check("wait_bus", 64'({BUSY, SEL, RnW, DATA_OUT_DUT}), 64'({1'b1, 3'd2, 1'b0, 16'h5555}));
        RST = 1'b1;
        #1;
        check("mid_reset_ctrl", 64'({CMD_READY, RSP_VALID, BUSY, START_FLAG, SEL, ADR, RnW, DATA_OUT_DUT}), 64'(0));
        tick();
        tick();
        check("mid_reset_no_rsp", 64'(RSP_VALID), 64'(0));
        RST = 1'b0;
        tick();
        hv = vecs[0];
        run_vec(hv, "post_reset_head");

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-pressure: response held, next command waiting
        head = 32'h0C00_1010;
        mode = 0;
        send(2'b00, 3'd1, 6'd0, 16'h0, ok);
        wait_rsp(lat);
        CMD_IN    = {2'b00, 3'd3, 6'd0, 16'h0};
        CMD_VALID = 1'b1;
        head      = 32'hA5A5_5A5A;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_hold%0d", i), 64'({RSP_DATA, RSP_STATUS, RSP_CYCLES, RSP_VALID, CMD_READY}),
                  64'({32'h0C00_1010, 2'b00, 16'd0, 1'b1, 1'b0}));
            tick();
        end
        RSP_READY = 1'b1;
        tick();
        RSP_READY = 1'b0;
        check("bp_after_hs", 64'({CMD_READY, RSP_VALID}), 64'({1'b1, 1'b0}));
        tick();
        check("bp_accepted", 64'({CMD_READY, BUSY}), 64'({1'b0, 1'b1}));
        CMD_VALID = 1'b0;
        wait_rsp(lat);
        check("bp_second_latency", 64'(lat), 64'(3));
        check("bp_second_data", 64'(RSP_DATA), 64'(32'hA5A5_5A5A));
        handshake();

        check("start_single_cycle", 64'(dbl_start), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
